writeback_stage: RTL and testbench

//  MEM/WB pipeline register plus write-back logic of the 5-stage RV32I pipeline. Latches memory-stage results,

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/writeback_stage_if.sv | 34 +++
 rtl/writeback_stage_load_extend.sv | 31 +++
 rtl/writeback_stage.sv | 85 ++++++++
 tb/tb_writeback_stage.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline constants: result-select codes and load funct3 encodings.
// Used by control, memory and write-back stages.
package pipe_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    RESULT_ALU  = 2'b00,
    RESULT_LOAD = 2'b01,
    RESULT_PC4  = 2'b10,
    RESULT_RSVD = 2'b11
  } result_src_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/writeback_stage_if.sv
// M->W bundle, W-stage controls and write-back outputs.
// master = upstream/testbench side, slave = write-back stage.
interface writeback_stage_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
);
  logic            ValidM;
  logic            RegWriteM;
  logic [1:0]      ResultSrcM;
  logic [4:0]      RdM;
  logic [2:0]      funct3M;
  logic [XLEN-1:0] ALUResultM;
  logic [XLEN-1:0] ReadDataM;
  logic [XLEN-1:0] PCPlus4M;
  logic            StallW;
  logic            FlushW;
  logic            RegWriteW;
  logic [4:0]      RdW;
  logic [XLEN-1:0] ResultW;
  logic            ValidW;
  logic [CNT_W-1:0] InstRet;

  modport master (
    output ValidM, RegWriteM, ResultSrcM, RdM, funct3M,
    output ALUResultM, ReadDataM, PCPlus4M, StallW, FlushW,
    input  RegWriteW, RdW, ResultW, ValidW, InstRet
  );

  modport slave (
    input  ValidM, RegWriteM, ResultSrcM, RdM, funct3M,
    input  ALUResultM, ReadDataM, PCPlus4M, StallW, FlushW,
    output RegWriteW, RdW, ResultW, ValidW, InstRet
  );
endinterface

// File: rtl/writeback_stage_load_extend.sv
// Load data extraction: picks byte/halfword by offset and
// sign/zero-extends by funct3. Purely combinational.
module load_extend
  import pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      off_i,
  input  logic [XLEN-1:0] word_i,
  output logic [XLEN-1:0] ext_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Halfword select ignores off[0]; misalignment is trapped upstream.
  always_comb begin
    byte_v = word_i[{off_i, 3'b000} +: 8];
    half_v = word_i[{off_i[1], 4'b0000} +: 16];
    ext_o  = word_i;
    unique case (funct3_i)
      F3_LB:   ext_o = {{(XLEN-8){byte_v[7]}}, byte_v};
      F3_LBU:  ext_o = {{(XLEN-8){1'b0}}, byte_v};
      F3_LH:   ext_o = {{(XLEN-16){half_v[15]}}, half_v};
      F3_LHU:  ext_o = {{(XLEN-16){1'b0}}, half_v};
      default: ext_o = word_i;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB register, result select, reg-file write gating
// and retired-instruction counter.
module writeback_stage
  import pipe_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input logic clk,
  input logic rst,
  writeback_stage_if.slave bus
);

  logic            valid_q;
  logic            regwrite_q;
  logic [1:0]      src_q;
  logic [4:0]      rd_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] alu_q;
  logic [XLEN-1:0] rdata_q;
  logic [XLEN-1:0] pc4_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [XLEN-1:0] load_ext;
  logic [XLEN-1:0] result;

  // W pipeline register: reset > flush > stall > capture.
  always_ff @(posedge clk) begin
    if (rst || bus.FlushW) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      src_q      <= '0;
      rd_q       <= '0;
      f3_q       <= '0;
      alu_q      <= '0;
      rdata_q    <= '0;
      pc4_q      <= '0;
    end else if (!bus.StallW) begin
      valid_q    <= bus.ValidM;
      regwrite_q <= bus.RegWriteM & bus.ValidM;
      src_q      <= bus.ResultSrcM;
      rd_q       <= bus.RdM;
      f3_q       <= bus.funct3M;
      alu_q      <= bus.ALUResultM;
      rdata_q    <= bus.ReadDataM;
      pc4_q      <= bus.PCPlus4M;
    end
  end

  // A stalled instruction counts once, when it finally leaves W.
  always_comb begin
    cnt_d = cnt_q;
    if (valid_q && !bus.StallW) cnt_d = cnt_q + 1'b1;
  end

  // Retired counter; reset discards the in-flight instruction.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  load_extend #(.XLEN(XLEN)) u_ext (
    .funct3_i (f3_q),
    .off_i    (alu_q[1:0]),
    .word_i   (rdata_q),
    .ext_o    (load_ext)
  );

  // Final result select; reserved code falls back to ALU.
  always_comb begin
    result = alu_q;
    unique case (1'b1)
      (src_q == RESULT_LOAD): result = load_ext;
      (src_q == RESULT_PC4):  result = pc4_q;
      default:                result = alu_q;
    endcase
  end

  assign bus.RegWriteW = regwrite_q & valid_q & (rd_q != 5'd0);
  assign bus.RdW       = rd_q;
  assign bus.ResultW   = result;
  assign bus.ValidW    = valid_q;
  assign bus.InstRet   = cnt_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed vector bench for writeback_stage.
// Counter width reduced to 4 to exercise wrap-around.
module tb_writeback_stage;
  localparam int XLEN = 32;
  localparam int CW   = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  writeback_stage_if #(.XLEN(XLEN), .CNT_W(CW)) bus ();

  writeback_stage #(.XLEN(XLEN), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int m_cnt  = 0;
  bit m_valid = 1'b0;

  typedef struct {
    string       name;
    logic        vm;
    logic        rw;
    logic [1:0]  src;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] pc4;
    logic        e_rw;
    logic        e_valid;
    logic [31:0] e_res;
  } vec_t;

  vec_t vecs [$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic set_m(input logic vm, input logic rw,
                       input logic [1:0] src, input logic [4:0] rd,
                       input logic [2:0] f3, input logic [31:0] alu,
                       input logic [31:0] rdata, input logic [31:0] pc4);
    bus.ValidM     = vm;
    bus.RegWriteM  = rw;
    bus.ResultSrcM = src;
    bus.RdM        = rd;
    bus.funct3M    = f3;
    bus.ALUResultM = alu;
    bus.ReadDataM  = rdata;
    bus.PCPlus4M   = pc4;
  endtask

  // One clock with a reference model of ValidW and the counter.
  task automatic step();
    if (rst) begin
      m_cnt   = 0;
      m_valid = 1'b0;
    end else begin
      if (m_valid && !bus.StallW) m_cnt = (m_cnt + 1) % 16;
      if (bus.FlushW)       m_valid = 1'b0;
      else if (!bus.StallW) m_valid = bus.ValidM;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string nm);
    chk(nm, 32'(bus.InstRet), 32'(m_cnt));
  endtask

  initial begin
    logic [4:0]  h_rd;
    logic [31:0] h_res;
    int          h_cnt;

    vecs.push_back('{"alu",    1,1,2'b00,5'd5,3'b010,32'h1234,0,0,1,1,32'h1234});
    vecs.push_back('{"lb_o1",  1,1,2'b01,5'd6,3'b000,32'h1001,32'h80FF7F01,0,1,1,32'h0000007F});
    vecs.push_back('{"lb_o2",  1,1,2'b01,5'd6,3'b000,32'h1002,32'h80FF7F01,0,1,1,32'hFFFFFFFF});
    vecs.push_back('{"lbu_o2", 1,1,2'b01,5'd6,3'b100,32'h1002,32'h80FF7F01,0,1,1,32'h000000FF});
    vecs.push_back('{"lb_o3",  1,1,2'b01,5'd6,3'b000,32'h1003,32'h80FF7F01,0,1,1,32'hFFFFFF80});
    vecs.push_back('{"lb_o0",  1,1,2'b01,5'd6,3'b000,32'h1000,32'h80FF7F01,0,1,1,32'h00000001});
    vecs.push_back('{"lh_o2",  1,1,2'b01,5'd7,3'b001,32'h1002,32'h80FF7F01,0,1,1,32'hFFFF80FF});
    vecs.push_back('{"lhu_o2", 1,1,2'b01,5'd7,3'b101,32'h1002,32'h80FF7F01,0,1,1,32'h000080FF});
    vecs.push_back('{"lh_o0",  1,1,2'b01,5'd7,3'b001,32'h1000,32'h80FF7F01,0,1,1,32'h00007F01});
    vecs.push_back('{"lhu_o1", 1,1,2'b01,5'd7,3'b101,32'h1001,32'h80FF7F01,0,1,1,32'h00007F01});
    vecs.push_back('{"lw",     1,1,2'b01,5'd8,3'b010,32'h1000,32'h80FF7F01,0,1,1,32'h80FF7F01});
    vecs.push_back('{"lw_f3_6",1,1,2'b01,5'd8,3'b110,32'h1003,32'h80FF7F01,0,1,1,32'h80FF7F01});
    vecs.push_back('{"x0",     1,1,2'b00,5'd0,3'b010,32'h55,0,0,0,1,32'h55});
    vecs.push_back('{"jal",    1,1,2'b10,5'd1,3'b010,32'h9,0,32'h104,1,1,32'h104});
    vecs.push_back('{"rsvd",   1,1,2'b11,5'd9,3'b010,32'hABCD,0,32'h4,1,1,32'hABCD});
    vecs.push_back('{"no_rw",  1,0,2'b00,5'd10,3'b010,32'h66,0,0,0,1,32'h66});
    vecs.push_back('{"bubble", 0,1,2'b00,5'd11,3'b010,32'h77,0,0,0,0,32'h77});

    rst = 1'b1;
    bus.StallW = 1'b0;
    bus.FlushW = 1'b0;
    set_m(1, 1, 2'b00, 5'd3, 3'b010, 32'hDEAD, 32'hBEEF, 32'h8);
    step();
    step();
    chk("rst_regwrite", 32'(bus.RegWriteW), 0);
    chk("rst_valid",    32'(bus.ValidW), 0);
    chk("rst_instret",  32'(bus.InstRet), 0);
    chk("rst_result",   bus.ResultW, 0);
    chk("rst_rd",       32'(bus.RdW), 0);

    rst = 1'b0;
    foreach (vecs[i]) begin
      set_m(vecs[i].vm, vecs[i].rw, vecs[i].src, vecs[i].rd,
            vecs[i].f3, vecs[i].alu, vecs[i].rdata, vecs[i].pc4);
      step();
      chk({vecs[i].name, "_rw"},  32'(bus.RegWriteW), 32'(vecs[i].e_rw));
      chk({vecs[i].name, "_vld"}, 32'(bus.ValidW), 32'(vecs[i].e_valid));
      chk({vecs[i].name, "_rd"},  32'(bus.RdW), 32'(vecs[i].rd));
      chk({vecs[i].name, "_res"}, bus.ResultW, vecs[i].e_res);
      chk_cnt({vecs[i].name, "_cnt"});
    end

    // ALU op first-instruction latency and InstRet=1 after reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_m(1, 1, 2'b00, 5'd5, 3'b010, 32'h1234, 0, 0);
    step();
    set_m(0, 0, 2'b00, 5'd0, 3'b010, 0, 0, 0);
    step();
    chk("alu_cnt_one", 32'(bus.InstRet), 1);

    // stall holds W contents and counter
    set_m(1, 1, 2'b00, 5'd9, 3'b010, 32'h77, 0, 0);
    step();
    h_rd  = bus.RdW;
    h_res = bus.ResultW;
    h_cnt = m_cnt;
    bus.StallW = 1'b1;
    set_m(1, 1, 2'b10, 5'd12, 3'b010, 32'h1, 0, 32'h999);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_rd",  32'(bus.RdW), 32'(h_rd));
      chk("stall_res", bus.ResultW, h_res);
      chk("stall_rw",  32'(bus.RegWriteW), 1);
      chk("stall_cnt", 32'(bus.InstRet), 32'(h_cnt));
    end
    bus.FlushW = 1'b1;
    step();
    chk("flstl_valid", 32'(bus.ValidW), 0);
    chk("flstl_rw",    32'(bus.RegWriteW), 0);
    chk_cnt("flstl_cnt");

    // flush alone still counts the exiting instruction
    bus.StallW = 1'b0;
    bus.FlushW = 1'b0;
    step();
    h_cnt = int'(bus.InstRet);
    bus.FlushW = 1'b1;
    step();
    chk("flush_cnt",   32'(bus.InstRet), 32'((h_cnt + 1) % 16));
    chk("flush_valid", 32'(bus.ValidW), 0);
    bus.FlushW = 1'b0;

    // counter wrap: 16 retirements bring InstRet back to 0
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_m(1, 1, 2'b00, 5'd4, 3'b010, 32'h10, 0, 0);
    for (int k = 0; k < 16; k++) step();
    chk("wrap_15", 32'(bus.InstRet), 15);
    set_m(0, 0, 2'b00, 5'd0, 3'b010, 0, 0, 0);
    step();
    chk("wrap_0", 32'(bus.InstRet), 0);
    chk_cnt("wrap_model");

    // reset in the middle of a stall
    set_m(1, 1, 2'b00, 5'd13, 3'b010, 32'h42, 0, 0);
    step();
    bus.StallW = 1'b1;
    step();
    rst = 1'b1;
    step();
    chk("rststl_cnt",   32'(bus.InstRet), 0);
    chk("rststl_rw",    32'(bus.RegWriteW), 0);
    chk("rststl_valid", 32'(bus.ValidW), 0);
    rst = 1'b0;
    bus.StallW = 1'b0;
    set_m(0, 1, 2'b00, 5'd14, 3'b010, 0, 0, 0);
    step();
    chk("post_rst_rw",  32'(bus.RegWriteW), 0);
    chk("post_rst_cnt", 32'(bus.InstRet), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
